// File: rtl/bsg_dff_gatestack_sequencer.sv
// Write sequencer for a bsg_dff_gatestack bank: latches one masked write, holds
// the data stable, then pulses the gate lines of the masked bits one group at a time.
module bsg_dff_gatestack_sequencer #(
  parameter int width_p        = 16,
  parameter int group_p        = 4,
  parameter int pulse_cycles_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic [width_p-1:0] mask_i,
  output logic               ready_o,
  output logic [width_p-1:0] gs_data_o,
  output logic [width_p-1:0] gs_gate_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int groups_lp = width_p / group_p;
  localparam int ptr_w_lp  = (groups_lp > 1) ? $clog2(groups_lp) : 1;
  localparam int cnt_w_lp  = $clog2(pulse_cycles_p + 1);
  localparam logic [cnt_w_lp-1:0] cnt_init_lp = cnt_w_lp'(pulse_cycles_p - 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_e;

  state_e              state_q, state_d;
  logic [width_p-1:0]  mask_q, mask_d;
  logic [width_p-1:0]  data_q, data_d;
  logic [width_p-1:0]  gate_q, gate_d;
  logic [ptr_w_lp-1:0] ptr_q, ptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                done_q, done_d;

  logic [groups_lp-1:0] in_nz, cur_nz;
  logic [ptr_w_lp-1:0]  first_ptr, next_ptr;
  logic                 first_vld, next_vld;

  function automatic logic [width_p-1:0] win(input logic [ptr_w_lp-1:0] p);
    win = '0;
    for (int k = 0; k < groups_lp; k++)
      if (p == ptr_w_lp'(k)) win[k*group_p +: group_p] = '1;
  endfunction

  // Descending scans so the lowest qualifying group wins.
  always_comb begin
    in_nz     = '0;
    cur_nz    = '0;
    first_ptr = '0;
    first_vld = 1'b0;
    next_ptr  = '0;
    next_vld  = 1'b0;
    for (int k = 0; k < groups_lp; k++) begin
      in_nz[k]  = |mask_i[k*group_p +: group_p];
      cur_nz[k] = |mask_q[k*group_p +: group_p];
    end
    for (int k = groups_lp - 1; k >= 0; k--) begin
      if (in_nz[k]) begin
        first_ptr = ptr_w_lp'(k);
        first_vld = 1'b1;
      end
      if (cur_nz[k] && (ptr_w_lp'(k) > ptr_q)) begin
        next_ptr = ptr_w_lp'(k);
        next_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gate_d  = '0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (v_i) begin
          data_d = data_i;
          mask_d = mask_i;
          if (first_vld) begin
            state_d = SETUP;
            ptr_d   = first_ptr;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d = PULSE;
        cnt_d   = cnt_init_lp;
        gate_d  = mask_q & win(ptr_q);
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
        end else begin
          cnt_d  = cnt_q - cnt_w_lp'(1);
          gate_d = mask_q & win(ptr_q);
        end
      end
      HOLD: begin
        if (next_vld) begin
          state_d = PULSE;
          ptr_d   = next_ptr;
          cnt_d   = cnt_init_lp;
          gate_d  = mask_q & win(next_ptr);
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      data_q  <= '0;
      gate_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      gate_q  <= gate_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign ready_o   = reset_n_i && (state_q == IDLE);
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign gs_data_o = data_q;
  assign gs_gate_o = gate_q;

endmodule

// File: tb/tb_bsg_dff_gatestack_sequencer.sv
// Scoreboard bench for bsg_dff_gatestack_sequencer with a behavioural gatestack model.
module tb_bsg_dff_gatestack_sequencer;

  logic        clk;
  logic        reset_n_i;
  logic        v_i;
  logic [15:0] data_i, mask_i;
  logic        ready_o, busy_o, done_o;
  logic [15:0] gs_data_o, gs_gate_o;

  typedef struct {
    bit          done;
    logic [15:0] gate;
    int          cyc;
  } ev_t;

  ev_t         exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model;

  bsg_dff_gatestack_sequencer #(.width_p(16), .group_p(4), .pulse_cycles_p(1)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i), .mask_i(mask_i),
    .ready_o(ready_o), .gs_data_o(gs_data_o), .gs_gate_o(gs_gate_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push_gate(input int c, input logic [15:0] g);
    ev_t e;
    e.done = 1'b0; e.gate = g; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int c);
    ev_t e;
    e.done = 1'b1; e.gate = 16'h0; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic accept(input logic [15:0] d, input logic [15:0] m);
    v_i = 1'b1; data_i = d; mask_i = m;
  endtask

  // Gatestack model plus output monitor, sampled on the falling edge.
  task automatic monitor();
    logic [15:0] prev;
    logic [15:0] rise;
    ev_t e;
    prev = 16'h0;
    forever begin
      @(negedge clk);
      rise  = gs_gate_o & ~prev;
      model = (model & ~rise) | (gs_data_o & rise);
      prev  = gs_gate_o;
      if (gs_gate_o !== 16'h0 || done_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got gate=%h done=%b at cycle %0d, required no activity",
                   gs_gate_o, done_o, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.gate !== gs_gate_o || e.done !== done_o || e.cyc != cyc) begin
            errors++;
            $display("FAIL scoreboard: got gate=%h done=%b at cycle %0d, required gate=%h done=%b at cycle %0d",
                     gs_gate_o, done_o, cyc, e.gate, e.done, e.cyc);
          end
        end
      end
      if (cyc > 3000) begin
        $display("FAIL watchdog: got cycle %0d, required end before 3000", cyc);
        $fatal(1, "watchdog expired");
      end
    end
  endtask

  task automatic stimulus();
    int c;
    // Reset held with v_i asserted
    reset_n_i = 1'b0; accept(16'hFFFF, 16'hFFFF);
    model = 16'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_gate", 32'(gs_gate_o), 32'h0);
      chk("rst_data", 32'(gs_data_o), 32'h0);
      chk("rst_ready", 32'(ready_o), 32'h0);
      chk("rst_done", 32'(done_o), 32'h0);
    end
    reset_n_i = 1'b1; v_i = 1'b0;
    #1;
    chk("ready_after_rst", 32'(ready_o), 32'h1);

    // Full write, then ignored requests while busy, then back-to-back accept
    tick(); c = cyc;
    accept(16'hA5C3, 16'hFFFF);
    push_gate(c+2, 16'h000F); push_gate(c+4, 16'h00F0);
    push_gate(c+6, 16'h0F00); push_gate(c+8, 16'hF000); push_done(c+10);
    tick();
    accept(16'h1234, 16'hFFFF);
    for (int i = 1; i <= 9; i++) begin
      chk("busy_hold_data", 32'(gs_data_o), 32'hA5C3);
      chk("busy_ready", 32'(ready_o), 32'h0);
      tick();
    end
    chk("done_cycle_ready", 32'(ready_o), 32'h1);
    chk("full_model", 32'(model), 32'hA5C3);
    push_gate(c+12, 16'h000F); push_gate(c+14, 16'h00F0);
    push_gate(c+16, 16'h0F00); push_gate(c+18, 16'hF000); push_done(c+20);
    tick(); v_i = 1'b0;
    chk("b2b_setup_busy", 32'(busy_o), 32'h1);
    chk("b2b_data", 32'(gs_data_o), 32'h1234);
    for (int i = 0; i < 10; i++) tick();
    chk("b2b_model", 32'(model), 32'h1234);

    // Sparse write
    model = 16'h0000;
    tick(); c = cyc;
    accept(16'hFFFF, 16'h8001);
    push_gate(c+2, 16'h0001); push_gate(c+4, 16'h8000); push_done(c+6);
    tick(); v_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("sparse_model", 32'(model), 32'h8001);
    chk("sparse_data", 32'(gs_data_o), 32'hFFFF);

    // Zero mask
    tick(); c = cyc;
    accept(16'h5555, 16'h0000);
    push_done(c+1);
    tick(); v_i = 1'b0;
    chk("zero_ready1", 32'(ready_o), 32'h1);
    chk("zero_busy", 32'(busy_o), 32'h0);
    tick();
    chk("zero_ready2", 32'(ready_o), 32'h1);
    chk("zero_data", 32'(gs_data_o), 32'h5555);
    chk("zero_model", 32'(model), 32'h8001);

    // Reset in the HOLD after the first group
    model = 16'h0000;
    tick(); c = cyc;
    accept(16'hFFFF, 16'hFFFF);
    push_gate(c+2, 16'h000F);
    tick(); v_i = 1'b0;
    tick();
    tick();
    reset_n_i = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready_o), 32'h0);
    tick();
    chk("midrst_gate", 32'(gs_gate_o), 32'h0);
    chk("midrst_busy", 32'(busy_o), 32'h0);
    tick();
    reset_n_i = 1'b1;
    chk("midrst_gate2", 32'(gs_gate_o), 32'h0);
    for (int i = 0; i < 8; i++) tick();
    chk("midrst_model", 32'(model), 32'h000F);
    chk("midrst_data", 32'(gs_data_o), 32'h0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    v_i = 1'b0; data_i = '0; mask_i = '0; reset_n_i = 1'b0;
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
